// File: rtl/sad_pkg.sv
// ---------------------------------------------------------------------------
// sad_pkg
// Shared definitions for the streaming SAD/SSD engine:
//   state_e      - control FSM states
//   MODE_SAD/SSD - encoding of the Mode input
//   lane_term_w  - width of one per-lane difference term for a given mode
//   lane_sum_w   - width of the sum of all lane terms in one memory word
// ---------------------------------------------------------------------------
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam logic MODE_SAD = 1'b0;
  localparam logic MODE_SSD = 1'b1;

  // An absolute difference fits in D_WIDTH bits; its square needs twice that.
  function automatic int lane_term_w(input int d_width, input logic mode);
    return (mode == MODE_SSD) ? 2 * d_width : d_width;
  endfunction

  // Sized for the widest term (SSD) plus growth from adding LANES of them.
  function automatic int lane_sum_w(input int d_width, input int lanes);
    return 2 * d_width + $clog2(lanes);
  endfunction

endpackage

// File: rtl/sad_lane_diff.sv
// ---------------------------------------------------------------------------
// sad_lane_diff
// Combinational per-word difference stage. Splits two packed words into
// LANES unsigned elements, forms |a-b| (SAD) or (a-b)^2 (SSD) per lane and
// returns the sum over all lanes.
// Ports:
//   mode_i - 0 = SAD, 1 = SSD
//   a_i    - packed word from memory A, lane 0 in the low bits
//   b_i    - packed word from memory B, same layout
//   sum_o  - lane sum of the selected difference terms
// ---------------------------------------------------------------------------
module sad_lane_diff
  import sad_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int LANES   = 4
) (
  input  logic                                     mode_i,
  input  logic [LANES*D_WIDTH-1:0]                 a_i,
  input  logic [LANES*D_WIDTH-1:0]                 b_i,
  output logic [lane_sum_w(D_WIDTH, LANES)-1:0]    sum_o
);

  localparam int SUM_W = lane_sum_w(D_WIDTH, LANES);
  localparam int ABS_W = lane_term_w(D_WIDTH, MODE_SAD);
  localparam int SQ_W  = lane_term_w(D_WIDTH, MODE_SSD);

  logic [SUM_W-1:0] term [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [D_WIDTH-1:0] a;
    logic [D_WIDTH-1:0] b;
    logic [ABS_W-1:0]   diff;
    logic [SQ_W-1:0]    diffExt;
    logic [SQ_W-1:0]    sq;

    assign a       = a_i[l*D_WIDTH +: D_WIDTH];
    assign b       = b_i[l*D_WIDTH +: D_WIDTH];
    // Subtract the smaller from the larger so the unsigned result is exact.
    assign diff    = (a >= b) ? ABS_W'(a - b) : ABS_W'(b - a);
    // Widen before multiplying so the square is not truncated.
    assign diffExt = SQ_W'(diff);
    assign sq      = diffExt * diffExt;
    assign term[l] = (mode_i == MODE_SAD) ? SUM_W'(diff) : SUM_W'(sq);
  end

  // Adder tree over the lanes; SUM_W already covers the worst-case growth.
  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_o = sum_o + term[l];
    end
  end

endmodule

// File: rtl/sad_stream.sv
// ---------------------------------------------------------------------------
// sad_stream
// Pipelined SAD/SSD engine. Streams LEN words from two synchronous block
// memories at one word per cycle, accumulates the lane differences into a
// saturating accumulator, aborts early once the running total exceeds Limit
// and holds the result until the next accepted Go.
// Ports:
//   Clk, Rst         - clock, synchronous active-high reset
//   Go, Mode, Limit  - start request, SAD/SSD select, abort threshold
//   A_Addr, B_Addr   - shared word address to both memories
//   A_Data, B_Data   - read data, READ_LAT cycles after the address
//   RW, En           - memory direction (always read) and read enable
//   Busy, Done, Over - run in progress, completion pulse, aborted flag
//   SAD_Out          - result of the last completed run
// ---------------------------------------------------------------------------
module sad_stream
  import sad_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int LANES     = 4,
  parameter int LEN       = 64,
  parameter int A_WIDTH   = 8,
  parameter int READ_LAT  = 2,
  parameter int OUT_WIDTH = 32
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Go,
  input  logic                       Mode,
  input  logic [OUT_WIDTH-1:0]       Limit,
  output logic [A_WIDTH-1:0]         A_Addr,
  output logic [A_WIDTH-1:0]         B_Addr,
  input  logic [LANES*D_WIDTH-1:0]   A_Data,
  input  logic [LANES*D_WIDTH-1:0]   B_Data,
  output logic                       RW,
  output logic                       En,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Over,
  output logic [OUT_WIDTH-1:0]       SAD_Out
);

  localparam int SUM_W  = lane_sum_w(D_WIDTH, LANES);
  localparam int WIDE_W = ((OUT_WIDTH > SUM_W) ? OUT_WIDTH : SUM_W) + 1;
  localparam logic [WIDE_W-1:0]   SAT_MAX   = WIDE_W'({OUT_WIDTH{1'b1}});
  localparam logic [A_WIDTH-1:0]  LAST_ADDR = A_WIDTH'(LEN - 1);
  // Every valid-pipe stage except the output one; when these are empty the
  // word being accumulated this cycle is the last one in flight.
  localparam logic [READ_LAT-1:0] EARLY_MASK = READ_LAT'((1 << (READ_LAT - 1)) - 1);

  state_e                state_q,  state_d;
  logic [A_WIDTH-1:0]    addr_q,   addr_d;
  logic                  en_q,     en_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic                  over_q,   over_d;
  logic [OUT_WIDTH-1:0]  sad_q,    sad_d;
  logic [OUT_WIDTH-1:0]  acc_q,    acc_d;
  logic                  mode_q,   mode_d;
  logic [OUT_WIDTH-1:0]  limit_q,  limit_d;
  logic [READ_LAT-1:0]   vpipe_q,  vpipe_d;

  logic [SUM_W-1:0]      laneSum;
  logic [WIDE_W-1:0]     accWide;
  logic [OUT_WIDTH-1:0]  accSum;
  logic                  wordValid;
  logic                  abort;
  logic                  finish;

  sad_lane_diff #(
    .D_WIDTH (D_WIDTH),
    .LANES   (LANES)
  ) u_lane_diff (
    .mode_i (mode_q),
    .a_i    (A_Data),
    .b_i    (B_Data),
    .sum_o  (laneSum)
  );

  // Saturating add: compute one bit wider than either operand and clamp.
  assign wordValid = vpipe_q[READ_LAT-1];
  assign accWide   = WIDE_W'(acc_q) + WIDE_W'(laneSum);
  assign accSum    = (accWide > SAT_MAX) ? {OUT_WIDTH{1'b1}} : accWide[OUT_WIDTH-1:0];

  // Next-state logic. The abort/finish block at the end overrides whatever
  // the state case chose, so an abort during ISSUE drops En immediately.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    over_d  = over_q;
    sad_d   = sad_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    limit_d = limit_q;
    vpipe_d = (vpipe_q << 1) | READ_LAT'(en_q);
    finish  = 1'b0;

    if (wordValid) begin
      acc_d = accSum;
    end
    abort = wordValid && (accSum > limit_q);

    unique case (state_q)
      IDLE: begin
        if (Go) begin
          state_d = ISSUE;
          mode_d  = Mode;
          limit_d = Limit;
          acc_d   = '0;
          addr_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          over_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (addr_q == LAST_ADDR) begin
          en_d    = 1'b0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if ((vpipe_q & EARLY_MASK) == '0) begin
          finish = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    // The result register takes the post-accumulate value so SAD_Out is
    // valid in the same cycle Done rises. Late data is flushed on exit.
    if (abort || finish) begin
      state_d = DONE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      sad_d   = acc_d;
      vpipe_d = '0;
      if (abort) begin
        over_d = 1'b1;
      end
    end
  end

  // State and output registers; reset clears everything including the
  // valid pipe so memory data still returning after reset is ignored.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      over_q  <= 1'b0;
      sad_q   <= '0;
      acc_q   <= '0;
      mode_q  <= MODE_SAD;
      limit_q <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      over_q  <= over_d;
      sad_q   <= sad_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
      vpipe_q <= vpipe_d;
    end
  end

  assign A_Addr  = addr_q;
  assign B_Addr  = addr_q;
  assign RW      = 1'b0;
  assign En      = en_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Over    = over_q;
  assign SAD_Out = sad_q;

endmodule

// File: tb/tb_sad_stream.sv
// ---------------------------------------------------------------------------
// tb_sad_stream
// Directed bench for sad_stream. Two instances: default geometry and one
// with a 16-bit accumulator for saturation. Each run pushes a modelled
// result into a queue when Go is driven and pops it when Done is seen.
// ---------------------------------------------------------------------------
module tb_sad_stream;

  localparam int RL   = 2;
  localparam int LEN  = 64;
  localparam int LNS  = 4;
  localparam int WW   = 32;

  typedef struct {
    longint sad;
    longint over;
    longint doneCyc;
    longint enCnt;
  } exp_t;

  logic Clk;
  logic Rst;
  logic Go;
  logic Mode;
  logic [31:0] Limit;
  logic curSel;

  logic go0, go16;
  logic [7:0] aAddr0, bAddr0, aAddr16, bAddr16;
  logic [WW-1:0] aData0, bData0, aData16, bData16;
  logic rw0, en0, busy0, done0, over0;
  logic rw16, en16, busy16, done16, over16;
  logic [31:0] sad0;
  logic [15:0] sad16;

  logic [WW-1:0] memA [LEN];
  logic [WW-1:0] memB [LEN];
  logic [WW-1:0] pA0 [RL];
  logic [WW-1:0] pB0 [RL];
  logic [WW-1:0] pA16 [RL];
  logic [WW-1:0] pB16 [RL];

  logic en_s, busy_s, done_s, over_s;
  logic [31:0] sad_s;
  logic [7:0] addr_s;

  exp_t sb[$];
  longint lastSad [2];
  int evalCount;
  int failCount;

  sad_stream dut0 (
    .Clk(Clk), .Rst(Rst), .Go(go0), .Mode(Mode), .Limit(Limit),
    .A_Addr(aAddr0), .B_Addr(bAddr0), .A_Data(aData0), .B_Data(bData0),
    .RW(rw0), .En(en0), .Busy(busy0), .Done(done0), .Over(over0), .SAD_Out(sad0)
  );

  sad_stream #(.OUT_WIDTH(16)) dut16 (
    .Clk(Clk), .Rst(Rst), .Go(go16), .Mode(Mode), .Limit(Limit[15:0]),
    .A_Addr(aAddr16), .B_Addr(bAddr16), .A_Data(aData16), .B_Data(bData16),
    .RW(rw16), .En(en16), .Busy(busy16), .Done(done16), .Over(over16), .SAD_Out(sad16)
  );

  assign go0    = Go & ~curSel;
  assign go16   = Go & curSel;
  assign en_s   = curSel ? en16   : en0;
  assign busy_s = curSel ? busy16 : busy0;
  assign done_s = curSel ? done16 : done0;
  assign over_s = curSel ? over16 : over0;
  assign sad_s  = curSel ? {16'h0, sad16} : sad0;
  assign addr_s = curSel ? aAddr16 : aAddr0;
  assign aData0  = pA0[RL-1];
  assign bData0  = pB0[RL-1];
  assign aData16 = pA16[RL-1];
  assign bData16 = pB16[RL-1];

  // Free-running clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous memories with RL cycles of read latency, one per instance.
  always @(posedge Clk) begin
    if (en0) begin
      pA0[0] <= memA[aAddr0[5:0]];
      pB0[0] <= memB[bAddr0[5:0]];
    end
    if (en16) begin
      pA16[0] <= memA[aAddr16[5:0]];
      pB16[0] <= memB[bAddr16[5:0]];
    end
    for (int i = 1; i < RL; i++) begin
      pA0[i]  <= pA0[i-1];
      pB0[i]  <= pB0[i-1];
      pA16[i] <= pA16[i-1];
      pB16[i] <= pB16[i-1];
    end
  end

  // Reference model: walks the memory words, saturates at the output width
  // and stops at the first accumulate that exceeds the limit.
  function automatic exp_t model(input logic mode, input longint limit, input int ow);
    exp_t e;
    longint acc;
    longint maxv;
    acc       = 0;
    maxv      = (longint'(1) << ow) - 1;
    e.over    = 0;
    e.doneCyc = LEN + RL + 1;
    e.enCnt   = LEN;
    for (int w = 0; w < LEN; w++) begin
      longint s;
      s = 0;
      for (int l = 0; l < LNS; l++) begin
        int a;
        int b;
        int d;
        a = int'(memA[w][l*8 +: 8]);
        b = int'(memB[w][l*8 +: 8]);
        d = (a > b) ? a - b : b - a;
        s += mode ? longint'(d * d) : longint'(d);
      end
      acc += s;
      if (acc > maxv) acc = maxv;
      if (acc > limit) begin
        e.over    = 1;
        e.doneCyc = w + RL + 2;
        e.enCnt   = (w + RL + 1 < LEN) ? w + RL + 1 : LEN;
        break;
      end
    end
    e.sad = acc;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    evalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fillConst(input logic [7:0] a, input logic [7:0] b);
    for (int w = 0; w < LEN; w++) begin
      for (int l = 0; l < LNS; l++) begin
        memA[w][l*8 +: 8] = a;
        memB[w][l*8 +: 8] = b;
      end
    end
  endtask

  task automatic fillRandom();
    for (int w = 0; w < LEN; w++) begin
      memA[w] = $urandom;
      memB[w] = $urandom;
    end
  endtask

  // Called in an IDLE cycle: this cycle becomes cycle 0 of the run.
  task automatic applyStimulus(input logic mode, input logic [31:0] limit);
    Mode  = mode;
    Limit = limit;
    Go    = 1'b1;
    sb.push_back(model(mode, longint'(limit), curSel ? 16 : 32));
  endtask

  // Follows one run cycle by cycle until Done, optionally pulsing Go at
  // cycle goPulse or keeping it high, then checks the popped expectation.
  // Returns at #1 in the cycle after Done (an IDLE cycle).
  task automatic observeRun(input int goPulse, input bit keepGo);
    exp_t e;
    int k;
    int enCnt;
    int busyBad;
    int addrBad;
    bit seen;
    k = 0; enCnt = 0; busyBad = 0; addrBad = 0; seen = 1'b0;
    while (!seen && k < 300) begin
      @(posedge Clk); #1;
      k++;
      if (!keepGo) Go = (k == goPulse);
      if (en_s) begin
        enCnt++;
        if (addr_s != 8'(k - 1)) addrBad++;
      end
      if (k == 1) begin
        checkOutput("sad_hold", sad_s, lastSad[curSel]);
        checkOutput("over_clr", over_s, 0);
      end
      if (done_s) begin
        seen = 1'b1;
        e = sb.pop_front();
        checkOutput("done_cycle", k, e.doneCyc);
        checkOutput("sad_out", sad_s, e.sad);
        checkOutput("over", over_s, e.over);
        checkOutput("en_cycles", enCnt, e.enCnt);
        checkOutput("addr_seq", addrBad, 0);
        checkOutput("busy_run", busyBad, 0);
        checkOutput("busy_at_done", busy_s, 0);
        lastSad[curSel] = e.sad;
      end else if (!busy_s) begin
        busyBad++;
      end
    end
    if (!seen) begin
      checkOutput("done_seen", done_s, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge Clk); #1;
    if (!keepGo) Go = 1'b0;
    checkOutput("done_pulse", done_s, 0);
    checkOutput("idle_en", en_s, 0);
    checkOutput("idle_busy", busy_s, 0);
    checkOutput("sad_held", sad_s, lastSad[curSel]);
  endtask

  initial begin
    int doneCnt;
    int enCnt;
    evalCount  = 0;
    failCount  = 0;
    lastSad[0] = 0;
    lastSad[1] = 0;
    Rst    = 1'b1;
    Go     = 1'b0;
    Mode   = 1'b0;
    Limit  = '0;
    curSel = 1'b0;
    fillConst(8'd10, 8'd3);
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("rst_en", en0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_over", over0, 0);
    checkOutput("rst_sad", sad0, 0);
    checkOutput("rst_addr", {aAddr0, bAddr0}, 0);
    checkOutput("rst_rw", rw0, 0);
    checkOutput("rst_sad16", sad16, 0);
    Rst = 1'b0;
    @(posedge Clk); #1;

    $display("[TB] uniform data SAD, SSD and abort");
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    observeRun(-1, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF);
    observeRun(-1, 1'b0);
    applyStimulus(1'b0, 32'd100);
    observeRun(-1, 1'b0);

    $display("[TB] ignored Go pulses and back-to-back runs");
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    observeRun(10, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    observeRun(67, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    observeRun(-1, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFFF);
    observeRun(-1, 1'b0);

    $display("[TB] reset in the middle of a run");
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      Go = 1'b0;
      if (k == 20) Rst = 1'b1;
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    void'(sb.pop_back());
    checkOutput("midrst_en", en0, 0);
    checkOutput("midrst_busy", busy0, 0);
    checkOutput("midrst_done", done0, 0);
    checkOutput("midrst_over", over0, 0);
    checkOutput("midrst_sad", sad0, 0);
    checkOutput("midrst_addr", {aAddr0, bAddr0}, 0);
    lastSad[0] = 0;
    doneCnt = 0;
    enCnt   = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge Clk); #1;
      if (done0) doneCnt++;
      if (en0 || busy0) enCnt++;
    end
    checkOutput("midrst_no_done", doneCnt, 0);
    checkOutput("midrst_quiet", enCnt, 0);
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    observeRun(-1, 1'b0);

    $display("[TB] random data");
    fillRandom();
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    observeRun(-1, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF);
    observeRun(-1, 1'b0);
    applyStimulus(1'b0, 32'd2000);
    observeRun(-1, 1'b0);

    $display("[TB] 16-bit accumulator saturation");
    curSel = 1'b1;
    fillConst(8'd255, 8'd0);
    applyStimulus(1'b1, 32'h0000_FFFF);
    observeRun(-1, 1'b0);
    applyStimulus(1'b0, 32'h0000_FFFF);
    observeRun(-1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
    $finish;
  end

endmodule
